scale_pixel_read_responder: RTL and testbench

Memory-side responder for the scale pixel generator's neighbour reads. Accepts one (x, y, tag) read request at a time, clamps coordinates to the source image, issues a single read to the synchronous source-frame SRAM and returns the pixel with the echoed tag and an out-of-bounds flag. It sits between the scale pixel generator (initiator of the A/B/C/D reads) and the source frame buffer.

---
 rtl/scale_pixel_read_responder_pkg.sv | 20 ++
 rtl/scale_pixel_addr_clamp.sv | 39 +++
 rtl/scale_pixel_read_responder.sv | 115 +++++++++++
 tb/tb_scale_pixel_read_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pixel_read_responder_pkg.sv
// Shared types for the scale pixel read responder.
//   STATES_t    : responder FSM state encoding
//   NEIGHBOUR_t : neighbour tag carried on req_tag / rsp_tag
package pkg_scalePixelReadResponder;

    typedef enum logic [1:0] {
        S_Idle,
        S_Issue,
        S_Wait,
        S_Hold
    } STATES_t;

    typedef enum logic [1:0] {
        N_A,
        N_B,
        N_C,
        N_D
    } NEIGHBOUR_t;

endpackage

// File: rtl/scale_pixel_addr_clamp.sv
// Combinational coordinate clamp and linear address generation.
// Ports:
//   x, y : requested column / row, may lie outside the image
//   addr : min(y, IMG_H-1) * IMG_W + min(x, IMG_W-1)
//   oob  : set when either coordinate had to be clamped
module scale_pixel_addr_clamp
    import pkg_scalePixelReadResponder::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

    logic           x_hi;
    logic           y_hi;
    logic [X_W-1:0] xc;
    logic [Y_W-1:0] yc;

    always_comb begin
        x_hi = (x > X_MAX);
        y_hi = (y > Y_MAX);
        xc   = x_hi ? X_MAX : x;
        yc   = y_hi ? Y_MAX : y;
        oob  = x_hi | y_hi;
        // Widen both operands first so the product never truncates.
        addr = ADDR_W'(yc) * ADDR_W'(IMG_W) + ADDR_W'(xc);
    end

endmodule

// File: rtl/scale_pixel_read_responder.sv
// Memory-side responder for the scale pixel generator's neighbour reads.
// One request in flight: clamp (x, y), issue one SRAM read, return the pixel
// with the echoed tag and an out-of-bounds flag.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/req_ready/req_x/y/tag  : request handshake and payload
//   rsp_valid/rsp_ready              : response handshake
//   rsp_pixel/rsp_tag/rsp_oob        : response payload (stable in S_Hold)
//   mem_rd_en/mem_addr/mem_rd_data   : synchronous SRAM port, 1-cycle latency
module scale_pixel_read_responder
    import pkg_scalePixelReadResponder::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 8,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [X_W-1:0]    req_x,
    input  logic [Y_W-1:0]    req_y,
    input  logic [1:0]        req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PIX_W-1:0]  rsp_pixel,
    output logic [1:0]        rsp_tag,
    output logic              rsp_oob,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data
);

    STATES_t           state;
    NEIGHBOUR_t        tag_q;
    logic              oob_q;
    logic [1:0]        rst_sync;
    logic              rst_int_n;
    logic [ADDR_W-1:0] clamp_addr;
    logic              clamp_oob;
    logic              accept;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    scale_pixel_addr_clamp #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_clamp (
        .x    (req_x),
        .y    (req_y),
        .addr (clamp_addr),
        .oob  (clamp_oob)
    );

    assign req_ready = (state == S_Idle) | ((state == S_Hold) & rsp_ready);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= S_Idle;
            tag_q     <= N_A;
            oob_q     <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_pixel <= '0;
            rsp_tag   <= '0;
            rsp_oob   <= 1'b0;
        end else begin
            case (state)
                S_Idle: ;
                S_Issue: begin
                    mem_rd_en <= 1'b0;
                    state     <= S_Wait;
                end
                S_Wait: begin
                    rsp_pixel <= mem_rd_data;
                    rsp_tag   <= tag_q;
                    rsp_oob   <= oob_q;
                    rsp_valid <= 1'b1;
                    state     <= S_Hold;
                end
                S_Hold: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_Idle;
                    end
                end
                default: state <= S_Idle;
            endcase

            // Accept from S_Idle or from S_Hold during the response handshake;
            // overrides the S_Hold -> S_Idle transition above.
            if (accept) begin
                mem_addr  <= clamp_addr;
                tag_q     <= NEIGHBOUR_t'(req_tag);
                oob_q     <= clamp_oob;
                mem_rd_en <= 1'b1;
                state     <= S_Issue;
            end
        end
    end

endmodule

// File: tb/tb_scale_pixel_read_responder.sv
module tb_scale_pixel_read_responder;

    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int PIX_W  = 8;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [X_W-1:0]    req_x;
    logic [Y_W-1:0]    req_y;
    logic [1:0]        req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [PIX_W-1:0]  rsp_pixel;
    logic [1:0]        rsp_tag;
    logic              rsp_oob;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rd_data;

    scale_pixel_read_responder #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (PIX_W),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_pixel   (rsp_pixel),
        .rsp_tag     (rsp_tag),
        .rsp_oob     (rsp_oob),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  pix;
        logic [1:0]        tag;
        logic              oob;
        int                acc;
    } exp_t;

    exp_t rd_q[$];
    exp_t rsp_q[$];
    int   hs_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rd_count = 0;
    int   acc_count = 0;
    bit   seen_head = 0;

    // SRAM contents: a fixed hash of the address.
    function automatic logic [PIX_W-1:0] pix_f(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return 8'(w ^ (w >> 8) ^ (w >> 16) ^ 32'h5A);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= pix_f(mem_addr);
        else           mem_rd_data <= 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: SRAM reads and response handshakes against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                rd_count++;
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = rd_q.pop_front();
                    check("rd_addr", 32'(mem_addr), 32'(e.addr));
                    check("rd_latency", cyc, e.acc + 1);
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    if (!seen_head) begin
                        check("rsp_latency", cyc, rsp_q[0].acc + 3);
                        seen_head = 1;
                    end
                    if (rsp_ready) begin
                        exp_t e;
                        e = rsp_q.pop_front();
                        check("rsp_pixel", 32'(rsp_pixel), 32'(e.pix));
                        check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                        check("rsp_oob", 32'(rsp_oob), 32'(e.oob));
                        hs_q.push_back(cyc);
                        seen_head = 0;
                    end
                end
            end
        end
    end

    // Drive one request; leaves req_valid high after the accepting edge.
    task automatic send(input int x, input int y, input logic [1:0] tag);
        bit   ok = 0;
        exp_t e;
        int   xe, ye;
        req_x     = X_W'(x);
        req_y     = Y_W'(y);
        req_tag   = tag;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                xe     = (x > IMG_W - 1) ? IMG_W - 1 : x;
                ye     = (y > IMG_H - 1) ? IMG_H - 1 : y;
                e.addr = ADDR_W'(ye * IMG_W + xe);
                e.pix  = pix_f(e.addr);
                e.tag  = tag;
                e.oob  = (x > IMG_W - 1) || (y > IMG_H - 1);
                e.acc  = cyc;
                rd_q.push_back(e);
                rsp_q.push_back(e);
                acc_count++;
                ok = 1;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && rsp_q.size() > 0; i++) @(posedge clk);
        if (rsp_q.size() > 0) check("drain_timeout", 32'(rsp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_req_ready"}, 32'(req_ready), 1);
        check({where, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({where, "_rsp_pixel"}, 32'(rsp_pixel), 0);
        check({where, "_rsp_tag"},   32'(rsp_tag), 0);
        check({where, "_rsp_oob"},   32'(rsp_oob), 0);
        check({where, "_mem_rd_en"}, 32'(mem_rd_en), 0);
        check({where, "_mem_addr"},  32'(mem_addr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PIX_W-1:0] hp;
        logic [1:0]       ht;
        logic             ho;
        bit               got;
        int               rv_cnt;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Single read, then clamp and corner cases.
        send(5, 2, 2'd0);
        req_valid = 1'b0;
        drain();
        send(700, 479, 2'd3);
        req_valid = 1'b0;
        drain();
        send(0, 0, 2'd1);
        send(639, 479, 2'd2);
        send(3, 500, 2'd1);
        send(1023, 511, 2'd0);
        req_valid = 1'b0;
        drain();

        // Backpressure: response must hold while a competing request waits.
        rsp_ready = 1'b0;
        send(100, 200, 2'd2);
        req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        check("bp_rsp_seen", 32'(got), 1);
        hp = rsp_pixel;
        ht = rsp_tag;
        ho = rsp_oob;
        req_x     = 10'd7;
        req_y     = 9'd7;
        req_tag   = 2'd1;
        req_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_pixel", 32'(rsp_pixel), 32'(hp));
            check("bp_tag", 32'(rsp_tag), 32'(ht));
            check("bp_oob", 32'(rsp_oob), 32'(ho));
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_mem_rd_en", 32'(mem_rd_en), 0);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        // Streaming A..D with back-to-back requests.
        hs_q.delete();
        send(1, 1, 2'd0);
        send(2, 1, 2'd1);
        send(1, 2, 2'd2);
        send(2, 2, 2'd3);
        req_valid = 1'b0;
        drain();
        check("stream_count", 32'(hs_q.size()), 4);
        if (hs_q.size() == 4)
            for (int i = 1; i < 4; i++)
                check("stream_spacing", hs_q[i] - hs_q[i-1], 3);

        // Reset while the read is in S_Wait: no response may follow.
        send(10, 10, 2'd1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        rsp_q.delete();
        rd_q.delete();
        seen_head = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rv_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || mem_rd_en) rv_cnt++;
        end
        check("no_rsp_after_reset", rv_cnt, 0);

        check("rd_count", rd_count, acc_count);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
